// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared types and elaboration helpers for pipelined_adder.
// Provides chunk_w(), the configuration check cfg_ok() and the stage valid vector type.
package pipelined_adder_pkg;

    // Deepest pipeline the valid shift register can describe.
    localparam int PA_MAX_STAGES = 64;

    // Per-stage valid bits; bit k is the valid flag of stage k.
    typedef logic [PA_MAX_STAGES-1:0] stage_vld_t;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // True when WIDTH splits into STAGES equal, non-empty chunks.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) &&
               (stages <= PA_MAX_STAGES) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational CW-bit ripple adder built from half-adder cells.
// Ports: a, b (CW), ci -> s (CW), co (carry out of MSB), c_msb (carry into MSB).
module adder_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          c_msb
);

    logic [CW:0]   w_c;
    logic [CW-1:0] w_hs;
    logic [CW-1:0] w_hc;
    logic [CW-1:0] w_pc;

    assign w_c[0] = ci;

    // Each bit is two half adders; their carries are ORed.
    for (genvar i = 0; i < CW; i++) begin : g_bit
        assign w_hs[i]   = a[i] ^ b[i];
        assign w_hc[i]   = a[i] & b[i];
        assign s[i]      = w_hs[i] ^ w_c[i];
        assign w_pc[i]   = w_hs[i] & w_c[i];
        assign w_c[i+1]  = w_hc[i] | w_pc[i];
    end

    assign co    = w_c[CW];
    assign c_msb = w_c[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES chunks, one chunk per stage.
// Ports: clk, rst_n, in_valid/in_ready, a, b, cin, [sub], out_valid/out_ready,
//        sum, cout, overflow. Optional macro PIPELINED_ADDER_SUB_EN adds `sub`.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = chunk_w(WIDTH, STAGES);

    localparam stage_vld_t VLD_MASK = stage_vld_t'({STAGES{1'b1}});

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic w_adv;
    logic w_sub_in;

`ifdef PIPELINED_ADDER_SUB_EN
    assign w_sub_in = sub;
`else
    assign w_sub_in = 1'b0;
`endif

    // Combinational view of each stage's inputs.
    logic [WIDTH-1:0] w_opa   [STAGES];
    logic [WIDTH-1:0] w_opb   [STAGES];
    logic             w_ci    [STAGES];
    logic             w_sub   [STAGES];
    logic [CW-1:0]    w_s     [STAGES];
    logic             w_co    [STAGES];
    logic             w_cm    [STAGES];
    logic [WIDTH-1:0] w_snext [STAGES];

    // Stage registers. Operands are kept right-aligned so the chunk
    // to add next always sits in the low CW bits.
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_c   [STAGES];
    logic             r_sub [STAGES];
    logic             r_ovf;
    stage_vld_t       r_vld;

    assign out_valid = r_vld[STAGES-1];
    assign w_adv     = !out_valid || out_ready;
    assign in_ready  = w_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld <= ((r_vld << 1) | stage_vld_t'(in_valid)) & VLD_MASK;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st

        if (k == 0) begin : g_head
            assign w_opa[k] = a;
            assign w_opb[k] = b;
            assign w_sub[k] = w_sub_in;
            // Subtract forces the +1 of the two's complement.
            assign w_ci[k]  = w_sub_in ? 1'b1 : cin;
            assign w_snext[k] = WIDTH'(w_s[k]) << (WIDTH - CW);
        end else begin : g_chain
            assign w_opa[k] = r_a[k-1];
            assign w_opb[k] = r_b[k-1];
            assign w_sub[k] = r_sub[k-1];
            assign w_ci[k]  = r_c[k-1];
            // New chunk enters at the top; older chunks slide down,
            // so after the last stage chunk 0 lands at bit 0.
            assign w_snext[k] = (r_s[k-1] >> CW) |
                                (WIDTH'(w_s[k]) << (WIDTH - CW));
        end

        adder_chunk #(
            .CW (CW)
        ) u_chunk (
            .a     (w_opa[k][CW-1:0]),
            .b     (w_opb[k][CW-1:0] ^ {CW{w_sub[k]}}),
            .ci    (w_ci[k]),
            .s     (w_s[k]),
            .co    (w_co[k]),
            .c_msb (w_cm[k])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end else if (w_adv) begin
                r_s[k] <= w_snext[k];
                r_c[k] <= w_co[k];
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a[k]   <= '0;
                    r_b[k]   <= '0;
                    r_sub[k] <= 1'b0;
                end else if (w_adv) begin
                    r_a[k]   <= w_opa[k] >> CW;
                    r_b[k]   <= w_opb[k] >> CW;
                    r_sub[k] <= w_sub[k];
                end
            end
        end

    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_cm[STAGES-1] ^ w_co[STAGES-1];
        end
    end

    assign sum      = r_s[STAGES-1];
    assign cout     = r_c[STAGES-1];
    assign overflow = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: self-checking bench for pipelined_adder (WIDTH=16, STAGES=4).
// Reference model works on integer arithmetic with a FIFO scoreboard.
module tb_pipelined_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         cin       = 1'b0;
    logic         sb_drv    = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic         cout;
    logic         overflow;
    logic [W-1:0] sum;

    pipelined_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub       (sb_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Integer model: unsigned sum mod 2^W, carry = result >= 2^W (or no
    // borrow), overflow = signed result outside the W-bit signed range.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        res_t   r;
        longint ux, uy, sx, sy, tot, stot;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sb) begin
            tot  = ux - uy;
            stot = sx - sy;
            r.c  = (ux >= uy);
        end else begin
            tot  = ux + uy + longint'(ci);
            stot = sx + sy + longint'(ci);
            r.c  = (tot >= (longint'(1) << W));
        end
        r.s = W'(tot);
        r.v = (stot > ((longint'(1) << (W-1)) - 1)) ||
              (stot < -(longint'(1) << (W-1)));
        return r;
    endfunction

    task automatic set_in(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sb, input logic ordy);
        in_valid  = v;
        a         = x;
        b         = y;
        cin       = ci;
        sb_drv    = sb;
        out_ready = ordy;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b expected 0", out_valid);
        end
        checks++;
        if (sum !== '0) begin
            errors++;
            $display("FAIL reset_sum got %h expected 0000", sum);
        end
        checks++;
        if (cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got cout=%b ovf=%b expected 0/0", cout, overflow);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b expected 1", in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic [W-1:0] es [3];
        logic         ec [3];
        logic         ev [3];
        va = '{16'hFFFF, 16'h7FFF, 16'h8000};
        vb = '{16'h0001, 16'h0001, 16'h8000};
        es = '{16'h0000, 16'h8000, 16'h0000};
        ec = '{1'b1, 1'b0, 1'b1};
        ev = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            int lat;
            lat = -1;
            for (int c = 0; c < 12 && lat < 0; c++) begin
                @(negedge clk);
                if (c == 0) set_in(1'b1, va[i], vb[i], 1'b0, 1'b0, 1'b1);
                else        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
                #1;
                if (out_valid) lat = c;
            end
            checks++;
            if (lat != S) begin
                errors++;
                $display("FAIL directed_latency[%0d] got %0d expected %0d", i, lat, S);
            end
            checks++;
            if (sum !== es[i] || cout !== ec[i] || overflow !== ev[i]) begin
                errors++;
                $display("FAIL directed_result[%0d] got %h/%b/%b expected %h/%b/%b",
                         i, sum, cout, overflow, es[i], ec[i], ev[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   first, last, nout;
        res_t e;
        first = -1;
        last  = -1;
        nout  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c < 8) set_in(1'b1, W'($urandom()), W'($urandom()),
                              1'($urandom_range(0, 1)), 1'b0, 1'b1);
            else       set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            #1;
            if (c < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready cycle %0d got %b expected 1", c, in_ready);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sb_drv));
            if (out_valid && out_ready) begin
                if (first < 0) first = c;
                last = c;
                nout++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra got %h expected no output", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({sum, cout, overflow} !== e) begin
                        errors++;
                        $display("FAIL b2b_result got %h/%b/%b expected %h/%b/%b",
                                 sum, cout, overflow, e.s, e.c, e.v);
                    end
                end
            end
        end
        checks++;
        if (first != S || last != S + 7 || nout != 8) begin
            errors++;
            $display("FAIL b2b_timing got first=%0d last=%0d n=%0d expected %0d/%0d/8",
                     first, last, nout, S, S + 7);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] pa [6];
        logic [W-1:0] pb [6];
        int           idx, nout;
        logic         ordy;
        res_t         e;
        for (int i = 0; i < 6; i++) begin
            pa[i] = W'($urandom());
            pb[i] = W'($urandom());
        end
        idx  = 0;
        nout = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            ordy = (c >= 7);
            if (idx < 6) set_in(1'b1, pa[idx], pb[idx], 1'b0, 1'b0, ordy);
            else         set_in(1'b0, '0, '0, 1'b0, 1'b0, ordy);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sb_drv));
                idx++;
            end
            if (c >= 4 && c < 7) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || exp_q.size() == 0 ||
                    sum !== exp_q[0].s || cout !== exp_q[0].c) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d got rdy=%b vld=%b sum=%h cout=%b expected 0/1/head",
                             c, in_ready, out_valid, sum, cout);
                end
            end
            if (out_valid && out_ready) begin
                nout++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra got %h expected no output", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({sum, cout, overflow} !== e) begin
                        errors++;
                        $display("FAIL stall_result got %h/%b/%b expected %h/%b/%b",
                                 sum, cout, overflow, e.s, e.c, e.v);
                    end
                end
            end
        end
        checks++;
        if (nout != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain got %0d outputs, %0d left expected 6/0",
                     nout, exp_q.size());
        end
    endtask

    task automatic test_random_ready();
        int   nacc, nout;
        res_t e;
        nacc = 0;
        nout = 0;
        for (int c = 0; c < 95; c++) begin
            @(negedge clk);
            if (c < 80) set_in(1'($urandom_range(0, 1)), W'($urandom()), W'($urandom()),
                               1'($urandom_range(0, 1)), 1'b0,
                               ($urandom_range(0, 3) != 0));
            else        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sb_drv));
                nacc++;
            end
            if (out_valid && out_ready) begin
                nout++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL random_extra got %h expected no output", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({sum, cout, overflow} !== e) begin
                        errors++;
                        $display("FAIL random_result got %h/%b/%b expected %h/%b/%b",
                                 sum, cout, overflow, e.s, e.c, e.v);
                    end
                end
            end
        end
        checks++;
        if (nout != nacc || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_count got %0d outputs expected %0d", nout, nacc);
        end
    endtask

    task automatic test_reset_mid();
        int nout, when;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            set_in(c < 4, W'($urandom()), W'($urandom()), 1'b0, 1'b0, 1'b0);
        end
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_prefill got out_valid=%b expected 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got vld=%b sum=%h cout=%b ovf=%b expected all 0",
                     out_valid, sum, cout, overflow);
        end
        exp_q.delete();
        @(negedge clk);
        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        nout = 0;
        when = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 2) set_in(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1);
            else        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            #1;
            if (out_valid) begin
                nout++;
                when = c;
                checks++;
                if (sum !== 16'h0007 || cout !== 1'b0 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_result got %h/%b/%b expected 0007/0/0",
                             sum, cout, overflow);
                end
            end
        end
        checks++;
        if (nout != 1 || when != 2 + S) begin
            errors++;
            $display("FAIL midrst_count got n=%0d at %0d expected 1 at %0d",
                     nout, when, 2 + S);
        end
    endtask

`ifdef PIPELINED_ADDER_SUB_EN
    task automatic test_sub();
        logic [W-1:0] va [2];
        logic [W-1:0] vb [2];
        logic [W-1:0] es [2];
        logic         ec [2];
        va = '{16'h0005, 16'h0007};
        vb = '{16'h0007, 16'h0005};
        es = '{16'hFFFE, 16'h0002};
        ec = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            int lat;
            lat = -1;
            for (int c = 0; c < 12 && lat < 0; c++) begin
                @(negedge clk);
                // cin=1 on the first vector must be ignored while subtracting.
                if (c == 0) set_in(1'b1, va[i], vb[i], (i == 0), 1'b1, 1'b1);
                else        set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
                #1;
                if (out_valid) lat = c;
            end
            checks++;
            if (lat != S || sum !== es[i] || cout !== ec[i] || overflow !== 1'b0) begin
                errors++;
                $display("FAIL sub_result[%0d] got lat=%0d %h/%b/%b expected %0d %h/%b/0",
                         i, lat, sum, cout, overflow, S, es[i], ec[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random_ready();
        test_reset_mid();
`ifdef PIPELINED_ADDER_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
